// File: rtl/music_recorder.sv
// Music recorder: captures key presses as {rest, beat, note} records into a
// 64-entry song RAM, terminating each take with an 8'hFF end marker.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no take in progress; waiting for a record rising edge
// S_WAIT   | take started, leading silence is ignored
// S_NOTE   | a note is sounding; timing its length in beats
// S_REST   | silence between notes; timing its length in beats
// S_FINISH | writing the end marker, then back to idle
module music_recorder #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BEAT_FREQ = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       record,
  input  logic [7:0] key,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       full,
  output logic [5:0] len_out
);

  localparam int BEAT_CYCLES = CLK_FREQ / BEAT_FREQ;
  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [CW-1:0] CLK_LAST = CW'(BEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_NOTE,
    S_REST,
    S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    key_s1_q, key_s2_q;
  logic          rec_prev_q;
  logic [2:0]    note_q, note_d;
  logic [3:0]    beat_q, beat_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [5:0]    addr_q, addr_d;
  logic          wr_en_q, wr_en_d;
  logic [5:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          done_q, done_d;
  logic          full_q, full_d;

  logic          key_valid;
  logic [2:0]    key_code;
  logic          rec_rise;
  logic          beat_tick;
  logic [CW-1:0] clk_cnt_inc;
  logic [3:0]    beat_inc;
  logic          last_slot;

  // Key synchronizer and record edge history.
  // rec_prev_q resets high so a record input already high out of reset is
  // not mistaken for a fresh rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q   <= 8'h00;
      key_s2_q   <= 8'h00;
      rec_prev_q <= 1'b1;
    end else begin
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      rec_prev_q <= record;
    end
  end

  // Priority encode the synchronized keys: lowest pressed key wins.
  always_comb begin
    key_valid = |key_s2_q;
    key_code  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (key_s2_q[i]) key_code = 3'(i);
    end
  end

  assign rec_rise    = record & ~rec_prev_q;
  assign beat_tick   = (clk_cnt_q == CLK_LAST);
  assign clk_cnt_inc = beat_tick ? '0 : clk_cnt_q + 1'b1;
  assign beat_inc    = (beat_tick && beat_q != 4'd15) ? beat_q + 4'd1 : beat_q;
  // Address 63 is kept for the marker, so a data write at 62 fills the RAM.
  assign last_slot   = (addr_q == 6'd62);

  // Next-state, event detection and registered write requests.
  always_comb begin
    state_d   = state_q;
    note_d    = note_q;
    beat_d    = beat_q;
    clk_cnt_d = clk_cnt_q;
    addr_d    = addr_q;
    full_d    = full_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rec_rise) begin
          state_d   = S_WAIT;
          addr_d    = 6'd0;
          full_d    = 1'b0;
          beat_d    = 4'd0;
          clk_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (!record) begin
          state_d = S_FINISH;
        end else if (key_valid) begin
          state_d   = S_NOTE;
          note_d    = key_code;
          beat_d    = 4'd1;
          clk_cnt_d = '0;
        end
      end
      S_NOTE: begin
        if (!record || !key_valid || key_code != note_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {1'b0, beat_q, note_q};
          addr_d    = addr_q + 6'd1;
          beat_d    = 4'd1;
          clk_cnt_d = '0;
          if (!record || last_slot) begin
            state_d = S_FINISH;
            full_d  = last_slot;
          end else if (!key_valid) begin
            state_d = S_REST;
          end else begin
            note_d = key_code;
          end
        end else begin
          clk_cnt_d = clk_cnt_inc;
          beat_d    = beat_inc;
        end
      end
      S_REST: begin
        if (!record) begin
          state_d = S_FINISH;
        end else if (key_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = {1'b1, beat_q, 3'b000};
          addr_d    = addr_q + 6'd1;
          beat_d    = 4'd1;
          clk_cnt_d = '0;
          note_d    = key_code;
          if (last_slot) begin
            state_d = S_FINISH;
            full_d  = 1'b1;
          end else begin
            state_d = S_NOTE;
          end
        end else begin
          clk_cnt_d = clk_cnt_inc;
          beat_d    = beat_inc;
        end
      end
      S_FINISH: begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q;
        wr_data_d = 8'hFF;
        done_d    = 1'b1;
        beat_d    = 4'd0;
        clk_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, counters and write port registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      note_q    <= 3'd0;
      beat_q    <= 4'd0;
      clk_cnt_q <= '0;
      addr_q    <= 6'd0;
      full_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 6'd0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      note_q    <= note_d;
      beat_q    <= beat_d;
      clk_cnt_q <= clk_cnt_d;
      addr_q    <= addr_d;
      full_q    <= full_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign full    = full_q;
  assign len_out = addr_q;

endmodule

// File: tb/tb_music_recorder.sv
// Scoreboard bench for music_recorder: takes are described as segments of
// key values with durations; a reference model turns them into the records
// the song RAM should receive.
module tb_music_recorder;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       record = 1'b0;
  logic [7:0] key = 8'h00;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       done;
  logic       full;
  logic [5:0] len_out;

  music_recorder #(.CLK_FREQ(16), .BEAT_FREQ(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .record  (record),
    .key     (key),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .full    (full),
    .len_out (len_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] k;
    int         len;
  } seg_t;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] data;
    bit         marker;
    bit         full;
    logic [5:0] len;
  } exp_t;

  seg_t segs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowbit(input logic [7:0] k);
    for (int i = 0; i < 8; i++) if (k[i]) return i;
    return -1;
  endfunction

  // Reference model: merge segments into events by key code, drop leading
  // silence and a trailing rest, size each event in beats, stop at 63 records.
  task automatic model_take();
    int codes[$];
    int lens[$];
    int addr;
    bit is_full;
    exp_t e;
    foreach (segs[i]) begin
      int c;
      c = lowbit(segs[i].k);
      if (codes.size() > 0 && codes[codes.size()-1] == c)
        lens[lens.size()-1] += segs[i].len;
      else begin
        codes.push_back(c);
        lens.push_back(segs[i].len);
      end
    end
    while (codes.size() > 0 && codes[0] < 0) begin
      void'(codes.pop_front());
      void'(lens.pop_front());
    end
    addr = 0;
    is_full = 0;
    for (int i = 0; i < codes.size(); i++) begin
      int beat;
      if (codes[i] < 0 && i == codes.size() - 1) break;
      beat = 1 + (lens[i] - 1) / BC;
      if (beat > 15) beat = 15;
      e.addr   = 6'(addr);
      e.data   = (codes[i] >= 0) ? {1'b0, 4'(beat), 3'(codes[i])} : {1'b1, 4'(beat), 3'b000};
      e.marker = 0;
      e.full   = 0;
      e.len    = 6'(addr + 1);
      exp_q.push_back(e);
      addr++;
      if (addr == 63) begin
        is_full = 1;
        break;
      end
    end
    e.addr   = 6'(addr);
    e.data   = 8'hFF;
    e.marker = 1;
    e.full   = is_full;
    e.len    = 6'(addr);
    exp_q.push_back(e);
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %0h with nothing expected at %0t",
                   wr_addr, wr_data, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("done", 32'(done), 32'(e.marker));
          if (e.marker) begin
            chk("full_at_marker", 32'(full), 32'(e.full));
            chk("len_out_at_marker", 32'(len_out), 32'(e.len));
            chk("busy_at_marker", 32'(busy), 32'd0);
          end
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_without_write: done 1 wr_en 0 at %0t", $time);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (4) @(negedge clk);
  endtask

  // Drive one take; the final record drop lands in the same cycle the FSM
  // sees the key change after the last segment, so the stop wins.
  task automatic run_take();
    @(negedge clk);
    record = 1'b0;
    key = 8'h00;
    repeat (3) @(negedge clk);
    model_take();
    record = 1'b1;
    foreach (segs[i]) begin
      key = segs[i].k;
      repeat (segs[i].len) @(negedge clk);
    end
    key = 8'h00;
    repeat (2) @(negedge clk);
    record = 1'b0;
    wait_drain();
  endtask

  task automatic add(input logic [7:0] k, input int len);
    seg_t s;
    s.k = k;
    s.len = len;
    segs.push_back(s);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_len_out"}, 32'(len_out), 32'd0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single note of two beats.
    segs.delete();
    add(8'h01, 8);
    run_take();

    // Note, rest, note.
    segs.delete();
    add(8'h10, 8); add(8'h00, 4); add(8'h20, 4);
    run_take();

    // Long hold saturates the beat count.
    segs.delete();
    add(8'h01, 320);
    run_take();

    // Chords encode to the lowest key; same code merges; stop on a change.
    segs.delete();
    add(8'h00, 5); add(8'h06, 6); add(8'h02, 3); add(8'h04, 5);
    run_take();

    // Immediate stop with no keys: marker only.
    segs.delete();
    add(8'h00, 3);
    run_take();

    // Fill the RAM while record is held; later keys must be ignored.
    segs.delete();
    for (int i = 0; i < 70; i++) add((i % 2 == 0) ? 8'h01 : 8'h80, 1 + (i % 2));
    run_take();

    // Random takes.
    for (int t = 0; t < 6; t++) begin
      int n;
      segs.delete();
      n = $urandom_range(15, 5);
      for (int i = 0; i < n; i++) begin
        int kind;
        logic [7:0] k;
        kind = $urandom_range(2, 0);
        if (kind == 0) k = 8'h00;
        else if (kind == 1) k = 8'h01 << $urandom_range(7, 0);
        else k = 8'($urandom_range(255, 1));
        add(k, $urandom_range(12, 1));
      end
      run_take();
    end

    // Reset mid-note: outputs clear at once, no marker, no restart on held record.
    @(negedge clk);
    record = 1'b0;
    key = 8'h00;
    repeat (3) @(negedge clk);
    record = 1'b1;
    key = 8'h08;
    repeat (10) @(negedge clk);
    chk("busy_before_reset", 32'(busy), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_restart_after_reset", 32'(busy), 32'd0);
    segs.delete();
    add(8'h08, 5); add(8'h00, 2); add(8'h40, 9);
    run_take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
